// File: rtl/io_buf_bank.sv
// io_buf_bank: registered multi-channel pad buffer bank with synchronised, glitch-filtered inputs and registered tristate outputs.
// Define IO_BUF_BANK_FILTER_EN to build the per-channel stable-count glitch filter; otherwise O_DATA follows the synchroniser directly.
module io_buf_bank #(
  parameter int    WIDTH         = 8,
  parameter int    FILTER_CYCLES = 4,
  parameter string WEAK_KEEPER   = "NONE"
) (
  input  logic             C,
  input  logic             R,
  input  logic [WIDTH-1:0] I_PAD,
  input  logic [WIDTH-1:0] IN_EN,
  output logic [WIDTH-1:0] O_DATA,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL,
  input  logic [WIDTH-1:0] OUT_D,
  input  logic [WIDTH-1:0] OUT_T,
  output logic [WIDTH-1:0] O_PAD,
  output logic [WIDTH-1:0] O_PAD_OE
);
  localparam logic             K  = (WEAK_KEEPER == "PULLUP");
  localparam logic [WIDTH-1:0] KV = {WIDTH{K}};

  if (WIDTH < 1 || WIDTH > 64 || FILTER_CYCLES < 1 || FILTER_CYCLES > 255) begin : g_bad_cfg
    $error("io_buf_bank: parameter out of range");
  end

  logic [WIDTH-1:0] w_d;
  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] w_acc;

  // disabled channels read the keeper level instead of the pad
  assign w_d = (I_PAD & IN_EN) | (KV & ~IN_EN);

  // two-flop synchroniser, idles at the keeper level out of reset
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      r_s1 <= KV;
      r_s2 <= KV;
    end else begin
      r_s1 <= w_d;
      r_s2 <= r_s1;
    end
  end

`ifdef IO_BUF_BANK_FILTER_EN
  localparam int CW = $clog2(FILTER_CYCLES) + 1;
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [CW-1:0] r_cnt;
    assign w_acc[i] = (r_s2[i] != O_DATA[i]) && (r_cnt == CW'(FILTER_CYCLES - 1));
    // count consecutive disagreeing cycles; any agreement or an accepted change restarts the count
    always_ff @(posedge C or posedge R) begin
      if (R)
        r_cnt <= '0;
      else
        r_cnt <= (r_s2[i] == O_DATA[i] || w_acc[i]) ? '0 : r_cnt + 1'b1;
    end
  end
`else
  assign w_acc = r_s2 ^ O_DATA;
`endif

  // accepted changes flip O_DATA and fire a one-cycle edge pulse in the direction of the new value
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      O_DATA <= KV;
      RISE   <= '0;
      FALL   <= '0;
    end else begin
      O_DATA <= O_DATA ^ w_acc;
      RISE   <= w_acc & ~O_DATA;
      FALL   <= w_acc & O_DATA;
    end
  end

  // output path is a plain register stage, independent of the input path
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      O_PAD    <= '0;
      O_PAD_OE <= '0;
    end else begin
      O_PAD    <= OUT_D;
      O_PAD_OE <= ~OUT_T;
    end
  end
endmodule

// File: tb/tb_io_buf_bank.sv
// tb_io_buf_bank: window-rule model check every cycle plus hand-computed directed expectations.
module tb_io_buf_bank;
  localparam int W  = 8;
  localparam int FC = 4;
`ifdef IO_BUF_BANK_FILTER_EN
  localparam int FE = FC;
`else
  localparam int FE = 1;
`endif

  logic C = 1'b0;
  logic R = 1'b0;
  logic [W-1:0] I_PAD = '0, IN_EN = '0, OUT_D = '0, OUT_T = '1;
  logic [W-1:0] O_DATA, RISE, FALL, O_PAD, O_PAD_OE;
  logic [W-1:0] pu_od, pu_r, pu_f, pu_p, pu_oe;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 C = ~C;

  io_buf_bank #(.WIDTH(W), .FILTER_CYCLES(FC), .WEAK_KEEPER("PULLDOWN")) dut (
    .C(C), .R(R), .I_PAD(I_PAD), .IN_EN(IN_EN), .O_DATA(O_DATA), .RISE(RISE), .FALL(FALL),
    .OUT_D(OUT_D), .OUT_T(OUT_T), .O_PAD(O_PAD), .O_PAD_OE(O_PAD_OE));

  io_buf_bank #(.WIDTH(W), .FILTER_CYCLES(FC), .WEAK_KEEPER("PULLUP")) dut_pu (
    .C(C), .R(R), .I_PAD(I_PAD), .IN_EN(IN_EN), .O_DATA(pu_od), .RISE(pu_r), .FALL(pu_f),
    .OUT_D(OUT_D), .OUT_T(OUT_T), .O_PAD(pu_p), .O_PAD_OE(pu_oe));

  // model: a bit flips once the last FE synchronised samples all disagree with it
  logic [W-1:0] dh [0:FE];
  logic [W-1:0] eo, er, ef, ep, eoe, fl;

  always_comb begin
    fl = '1;
    for (int k = 1; k <= FE; k++) fl = fl & (dh[k] ^ eo);
  end

  always @(posedge C or posedge R) begin
    if (R) begin
      for (int k = 0; k <= FE; k++) dh[k] <= '0;
      eo <= '0; er <= '0; ef <= '0; ep <= '0; eoe <= '0;
    end else begin
      for (int k = 1; k <= FE; k++) dh[k] <= dh[k-1];
      dh[0] <= I_PAD & IN_EN;
      eo  <= eo ^ fl;
      er  <= fl & ~eo;
      ef  <= fl & eo;
      ep  <= OUT_D;
      eoe <= ~OUT_T;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  logic [W-1:0] tp [10] = '{8'hFF, 8'h00, 8'h5A, 8'h5B, 8'hA5, 8'h3C, 8'hC3, 8'h0F, 8'hF0, 8'h81};
  logic [W-1:0] te [10] = '{8'hFF, 8'hFF, 8'hF0, 8'hFF, 8'h0F, 8'hFF, 8'hFF, 8'hAA, 8'hFF, 8'hFF};
  int th [10] = '{6, 1, 5, 2, 7, 3, 6, 4, 8, 5};

  initial begin
    fork
      forever begin
        @(negedge C);
        chk("model_o_data", O_DATA, eo);
        chk("model_rise", RISE, er);
        chk("model_fall", FALL, ef);
        chk("model_o_pad", O_PAD, ep);
        chk("model_o_pad_oe", O_PAD_OE, eoe);
      end
      begin
        #1 R = 1'b1;
        @(negedge C);
        chk("rst_pu_o_data", pu_od, 8'hFF);
        chk("rst_o_data", O_DATA, 8'h00);
        chk("rst_oe", O_PAD_OE, 8'h00);
        R = 1'b0;
        repeat (4) begin
          @(negedge C);
          chk("rel_pu_o_data", pu_od, 8'hFF);
          chk("rel_pu_pulse", pu_r | pu_f, 8'h00);
        end
        IN_EN = '1; OUT_T = '0; OUT_D = '1; I_PAD = '0;
        repeat (FE + 3) @(negedge C);
        chk("pre_pu_o_data", pu_od, 8'h00);
        chk("pre_oe", O_PAD_OE, 8'hFF);
        I_PAD = 8'h01;
        repeat (2) @(negedge C);
        #2 R = 1'b1;
        #1;
        chk("arst_pu_o_data", pu_od, 8'hFF);
        chk("arst_pu_pulse", pu_r | pu_f, 8'h00);
        chk("arst_oe", O_PAD_OE, 8'h00);
        chk("arst_o_pad", O_PAD, 8'h00);
        @(negedge C);
        R = 1'b0; I_PAD = '0;
        repeat (FE + 3) @(negedge C);
        I_PAD = 8'h01;
        repeat (1 + FE) @(negedge C);
        chk("clean_o0_before", O_DATA[0], 1'b0);
        @(negedge C);
        chk("clean_o0", O_DATA[0], 1'b1);
        chk("clean_rise0", RISE[0], 1'b1);
        @(negedge C);
        chk("clean_rise0_gone", RISE[0], 1'b0);
        I_PAD = '0;
        repeat (FE + 4) @(negedge C);
`ifdef IO_BUF_BANK_FILTER_EN
        I_PAD = 8'h08;
        repeat (3) @(negedge C);
        I_PAD = '0;
        repeat (8) begin
          @(negedge C);
          chk("glitch_o3", O_DATA[3], 1'b0);
          chk("glitch_pulse3", RISE[3] | FALL[3], 1'b0);
        end
        I_PAD = 8'h08;
        repeat (4) @(negedge C);
        I_PAD = '0;
        repeat (2) @(negedge C);
        chk("pulse4_rise3", RISE[3], 1'b1);
        repeat (4) @(negedge C);
        chk("pulse4_fall3", FALL[3], 1'b1);
`else
        I_PAD = 8'h08;
        @(negedge C);
        I_PAD = '0;
        repeat (2) @(negedge C);
        chk("glitch_rise3", RISE[3], 1'b1);
        @(negedge C);
        chk("glitch_fall3", FALL[3], 1'b1);
`endif
        repeat (FE + 4) @(negedge C);
        I_PAD = 8'h04; IN_EN = 8'hFB;
        repeat (FE + 4) @(negedge C);
        chk("inen_o2_keeper", O_DATA[2], 1'b0);
        IN_EN = '1;
        repeat (1 + FE) @(negedge C);
        chk("inen_rise2_early", RISE[2], 1'b0);
        @(negedge C);
        chk("inen_rise2", RISE[2], 1'b1);
        chk("inen_o2", O_DATA[2], 1'b1);
        OUT_D = 8'hA5; OUT_T = 8'h0F;
        @(negedge C);
        chk("out_o_pad", O_PAD, 8'hA5);
        chk("out_oe", O_PAD_OE, 8'hF0);
        for (int j = 0; j < 10; j++) begin
          I_PAD = tp[j]; IN_EN = te[j]; OUT_D = tp[j] ^ 8'h33; OUT_T = te[j];
          repeat (th[j]) @(negedge C);
        end
        repeat (FE + 4) @(negedge C);
      end
    join_any
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
